hpf_mac_sequencer: RTL and testbench
====================================

Name: hpf_mac_sequencer

Overview:
- Time-multiplexed 9-tap symmetric FIR high-pass filter for the stereo audio path.
- One signed 16x16 multiplier and one 40-bit accumulator are shared across all taps of both channels.
- An FSM, triggered once per frame by the codec DAC LR clock, schedules the multiply-accumulate operations.
- Sits between the ADC sample register and the DAC serializer, on the fast system clock.

Parameters:
- C0, -177, tap 0/8 coefficient, signed 16-bit, Q(SHIFT)
- C1, 440, tap 1/7 coefficient
- C2, -393, tap 2/6 coefficient
- C3, -43, tap 3/5 coefficient
- C4, 325, centre tap 4 coefficient
- SHIFT, 10, arithmetic right shift applied to the accumulator before output

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- AUD_DACLRCK  in  1  codec DAC LR clock; asynchronous to clk
- audioIn  in  32  [31:16] left, [15:0] right; signed 16-bit samples
- audioOut  out  32  filtered output; [31:16] left, [15:0] right
- out_valid  out  1  one-cycle pulse when audioOut updates
- busy  out  1  high while the FSM is not in IDLE
- overrun  out  1  sticky; set when a frame tick is dropped

Behaviour:
- Frame tick generation:
  - AUD_DACLRCK passes through a 2-flop synchroniser, then a rising-edge detector.
  - tick = sync2 & ~sync3, one cycle wide.
  - tick is asserted 3 clk edges after the first edge that samples AUD_DACLRCK high.
- Delay lines: xl[0..8] and xr[0..8], signed 16-bit; index 0 is the newest sample.
- Impulse response: h = {C0,C1,C2,C3,C4,C3,C2,C1,C0}; y = sum over k of h[k]*x[k].
- FSM states:
  - IDLE: on tick (cycle T), shift both delay lines, load xl[0]=audioIn[31:16] and xr[0]=audioIn[15:0], clear acc, go to MAC_L.
  - MAC_L: cycles T+1..T+9, k=0..8, acc += h[k]*xl[k]. After k=8, latch the left result, clear acc, go to MAC_R.
  - MAC_R: cycles T+10..T+18, acc += h[k]*xr[k]. Then go to DONE.
  - DONE: cycle T+19, register both results into audioOut and pulse out_valid. out_valid and audioOut are visible after the T+19 edge, i.e. 20 clk edges after the tick edge. Return to IDLE.
- Tap counter: 4-bit, 0..8. It wraps to 0 on the MAC_L-to-MAC_R transition.
- Arithmetic:
  - Product is 32-bit signed; acc is 40-bit signed and never overflows.
  - Result = acc >>> SHIFT (floor), reduced to 16 bits as set by the optional feature.
- busy = (state != IDLE).
- Tick arriving while busy (including in DONE): the tick is ignored, audioIn is not captured, and overrun is set to 1.
- overrun is cleared only by rst.
- Reset, including mid-operation:
  - state=IDLE, tap counter=0, acc=0.
  - All delay-line entries and sync/edge flops = 0.
  - audioOut=0, out_valid=0, busy=0, overrun=0.
  - A partial result is discarded; no out_valid is issued for it.
- audioOut holds its value between updates.

Optional Feature:
- Macro: HPF_SAT_EN.
- Defined: the shifted result saturates to [-32768, 32767].
- Undefined: the shifted result is truncated to bits [15:0] (two's-complement wrap).
- All other behaviour, including timing, is identical in both builds.

Test Plan:
- Reset: hold rst high for 3 clk with random audioIn and toggling AUD_DACLRCK -> audioOut=0, out_valid=0, busy=0, overrun=0. First tick after release: out_valid exactly 20 clk after the tick, 1 cycle wide.
- Left impulse: left=1024 on one frame, 0 on the following frames; right=0 throughout -> left outputs in successive frames are -177, 440, -393, -43, 325, -43, -393, 440, -177, then 0. Right output stays 0.
- DC (right): right=1024 held constant -> right output settles to -21 from the 9th frame onward. Left stays 0.
- Saturation: left=+32767 on frames aligned to the positive taps and -32768 on frames aligned to the negative taps, so the 9-tap window gives an acc of 79657803 -> with HPF_SAT_EN, output 32767 (0x7FFF); without it, output 12254 (0x2FDE).
- Overrun: drive a second AUD_DACLRCK rising edge 10 clk after the first tick -> the second tick is ignored, overrun goes to 1, exactly one out_valid is issued, and the delay line shifts once.
- Reset mid-MAC: assert rst at T+12 -> no out_valid for that frame, the delay lines read 0, and the next frame's output uses only the new sample.

Source files
------------

// File: rtl/hpf_mac_sequencer_if.sv
// hpf_mac_sequencer_if: codec-side frame clock, stereo sample input and filtered output bundle.
interface hpf_mac_sequencer_if;
    logic        AUD_DACLRCK;
    logic [31:0] audioIn;
    logic [31:0] audioOut;
    logic        out_valid;
    logic        busy;
    logic        overrun;
    modport master (output AUD_DACLRCK, audioIn, input audioOut, out_valid, busy, overrun);
    modport slave (input AUD_DACLRCK, audioIn, output audioOut, out_valid, busy, overrun);
endinterface

// File: rtl/hpf_mac_sequencer.sv
// hpf_mac_sequencer: 9-tap symmetric FIR high-pass, one shared 16x16 MAC for both stereo channels.
// Define HPF_SAT_EN to saturate the output to 16 bits instead of wrapping.
module hpf_mac_sequencer #(
    parameter logic signed [15:0] C0 = -16'sd177,
    parameter logic signed [15:0] C1 = 16'sd440,
    parameter logic signed [15:0] C2 = -16'sd393,
    parameter logic signed [15:0] C3 = -16'sd43,
    parameter logic signed [15:0] C4 = 16'sd325,
    parameter int SHIFT = 10
) (
    input logic clk,
    input logic rst,
    hpf_mac_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MAC_L, MAC_R, DONE} state_t;
    state_t             state_q, state_d;
    logic [2:0]         sync_q, sync_d;
    logic signed [15:0] xl_q [9], xl_d [9], xr_q [9], xr_d [9];
    logic [3:0]         tap_q, tap_d;
    logic signed [39:0] acc_q, acc_d, acc_sum;
    logic [15:0]        left_q, left_d;
    logic [31:0]        out_q, out_d;
    logic               valid_q, valid_d, ovr_q, ovr_d;
    logic               tick;
    logic signed [15:0] mul_x, coef;
    logic signed [31:0] prod;

    function automatic logic [15:0] reduce(input logic signed [39:0] a);
`ifdef HPF_SAT_EN
        return (a >>> SHIFT) > 40'sd32767 ? 16'h7fff :
               (a >>> SHIFT) < -40'sd32768 ? 16'h8000 : 16'(a >>> SHIFT);
`else
        return 16'(a >>> SHIFT);
`endif
    endfunction

    assign tick = sync_q[1] & ~sync_q[2];
    assign sync_d = {sync_q[1:0], bus.AUD_DACLRCK};
    assign mul_x = (state_q == MAC_R) ? xr_q[tap_q] : xl_q[tap_q];
    // Symmetric response: tap k and tap 8-k share a coefficient
    assign coef = (tap_q == 4'd0 || tap_q == 4'd8) ? C0 :
                  (tap_q == 4'd1 || tap_q == 4'd7) ? C1 :
                  (tap_q == 4'd2 || tap_q == 4'd6) ? C2 :
                  (tap_q == 4'd3 || tap_q == 4'd5) ? C3 : C4;
    assign prod = 32'(mul_x) * 32'(coef);
    assign acc_sum = acc_q + 40'(prod);
    assign bus.audioOut = out_q;
    assign bus.out_valid = valid_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.overrun = ovr_q;

    always_comb begin
        state_d = state_q;
        tap_d = tap_q;
        acc_d = acc_q;
        left_d = left_q;
        out_d = out_q;
        valid_d = 1'b0;
        ovr_d = ovr_q | (tick & (state_q != IDLE));
        xl_d = xl_q;
        xr_d = xr_q;
        case (state_q)
            IDLE: if (tick) begin
                for (int i = 8; i > 0; i--) begin
                    xl_d[i] = xl_q[i-1];
                    xr_d[i] = xr_q[i-1];
                end
                xl_d[0] = bus.audioIn[31:16];
                xr_d[0] = bus.audioIn[15:0];
                acc_d = '0;
                tap_d = '0;
                state_d = MAC_L;
            end
            MAC_L: begin
                acc_d = (tap_q == 4'd8) ? '0 : acc_sum;
                tap_d = (tap_q == 4'd8) ? 4'd0 : tap_q + 4'd1;
                left_d = (tap_q == 4'd8) ? reduce(acc_sum) : left_q;
                state_d = (tap_q == 4'd8) ? MAC_R : MAC_L;
            end
            MAC_R: begin
                acc_d = acc_sum;
                tap_d = (tap_q == 4'd8) ? 4'd0 : tap_q + 4'd1;
                state_d = (tap_q == 4'd8) ? DONE : MAC_R;
            end
            DONE: begin
                out_d = {left_q, reduce(acc_q)};
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q <= '0;
            xl_q <= '{default: '0};
            xr_q <= '{default: '0};
            tap_q <= '0;
            acc_q <= '0;
            left_q <= '0;
            out_q <= '0;
            valid_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q <= sync_d;
            xl_q <= xl_d;
            xr_q <= xr_d;
            tap_q <= tap_d;
            acc_q <= acc_d;
            left_q <= left_d;
            out_q <= out_d;
            valid_q <= valid_d;
            ovr_q <= ovr_d;
        end
    end
endmodule

// File: tb/tb_hpf_mac_sequencer.sv
// tb_hpf_mac_sequencer: frame-level FIR model compared every cycle, plus hand-computed literal checks.
module tb_hpf_mac_sequencer;
    typedef struct {int t; logic [31:0] v;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int hc [9] = '{-177, 440, -393, -43, 325, -43, -393, 440, -177};
    int hl [9];
    int hr [9];
    int last_t, prev_t, ovr_t;
    logic [31:0] held;
    exp_t exp_q [$];

    hpf_mac_sequencer_if bus ();
    hpf_mac_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] fir(input int x [9]);
        longint acc, sh;
        acc = 0;
        for (int k = 0; k < 9; k++) acc += longint'(hc[k]) * longint'(x[k]);
        sh = acc >>> 10;
`ifdef HPF_SAT_EN
        if (sh > 32767) sh = 32767;
        else if (sh < -32768) sh = -32768;
`endif
        return sh[15:0];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 9; k++) begin
            hl[k] = 0;
            hr[k] = 0;
        end
        last_t = -1000;
        prev_t = -1000;
        ovr_t = 32'h7fffffff;
        held = '0;
        exp_q.delete();
    endtask

    // Rising LRCK at the negedge after edge c: the FSM acts on it at edge c+3
    task automatic raise(input logic signed [15:0] l, input logic signed [15:0] r);
        int t;
        t = cyc + 3;
        bus.audioIn = {l, r};
        bus.AUD_DACLRCK = 1'b1;
        if (t >= last_t + 20) begin
            for (int k = 8; k > 0; k--) begin
                hl[k] = hl[k-1];
                hr[k] = hr[k-1];
            end
            hl[0] = int'(l);
            hr[0] = int'(r);
            exp_q.push_back('{t + 19, {fir(hl), fir(hr)}});
            prev_t = last_t;
            last_t = t;
        end else if (t < ovr_t) ovr_t = t;
        repeat (4) @(negedge clk);
        bus.AUD_DACLRCK = 1'b0;
    endtask

    task automatic frame(input logic signed [15:0] l, input logic signed [15:0] r);
        raise(l, r);
        repeat (20) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            bus.audioIn = $urandom;
            bus.AUD_DACLRCK = ~bus.AUD_DACLRCK;
            @(negedge clk);
        end
        check("reset_out", bus.audioOut, 32'h0);
        check("reset_flags", {29'd0, bus.out_valid, bus.busy, bus.overrun}, 32'h0);
        rst = 1'b0;
        bus.AUD_DACLRCK = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic exp_valid, exp_busy;
        forever begin
            @(posedge clk);
            #1;
            exp_valid = (exp_q.size() > 0 && exp_q[0].t == cyc);
            if (exp_valid) begin
                held = exp_q[0].v;
                void'(exp_q.pop_front());
            end
            exp_busy = (cyc >= last_t && cyc <= last_t + 18) || (cyc >= prev_t && cyc <= prev_t + 18);
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
            check("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
            check("overrun", {31'd0, bus.overrun}, {31'd0, cyc >= ovr_t});
            check("audioOut", bus.audioOut, held);
        end
    end

    initial begin
        int c0, vc, n;
        int imp [10] = '{-177, 440, -393, -43, 325, -43, -393, 440, -177, 0};
        bus.AUD_DACLRCK = 1'b0;
        bus.audioIn = '0;
        do_reset();
        // Left impulse, first frame also pins the latency and pulse width
        c0 = cyc;
        raise(16'sd1024, 16'sd0);
        vc = -1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (vc < 0) vc = cyc;
                n++;
            end
        end
        check("tick_latency", vc, c0 + 22);
        check("valid_width", n, 1);
        check("impulse_0", bus.audioOut, {16'(imp[0]), 16'h0});
        for (int i = 1; i < 10; i++) begin
            frame(16'sd0, 16'sd0);
            check($sformatf("impulse_%0d", i), bus.audioOut, {16'(imp[i]), 16'h0});
        end
        // DC on the right channel
        for (int i = 0; i < 10; i++) frame(16'sd0, 16'sd1024);
        check("dc_right", bus.audioOut, {16'h0, 16'hffeb});
        // Saturation pattern: positive full-scale on positive taps
        do_reset();
        frame(-16'sd32768, 16'sd0);
        frame(16'sd32767, 16'sd0);
        frame(-16'sd32768, 16'sd0);
        frame(-16'sd32768, 16'sd0);
        frame(16'sd32767, 16'sd0);
        frame(-16'sd32768, 16'sd0);
        frame(-16'sd32768, 16'sd0);
        frame(16'sd32767, 16'sd0);
        frame(-16'sd32768, 16'sd0);
`ifdef HPF_SAT_EN
        check("saturate", bus.audioOut, {16'h7fff, 16'h0});
`else
        check("saturate", bus.audioOut, {16'h2fde, 16'h0});
`endif
        // Overrun: second tick lands 10 cycles after the first
        do_reset();
        c0 = cyc;
        raise(16'sd1024, 16'sd0);
        repeat (6) @(negedge clk);
        raise(16'sd2048, 16'sd0);
        n = 0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        check("overrun_valids", n, 1);
        check("overrun_flag", {31'd0, bus.overrun}, 32'd1);
        check("overrun_out", bus.audioOut, {16'hff4f, 16'h0});
        frame(16'sd0, 16'sd0);
        check("overrun_shift_once", bus.audioOut, {16'd440, 16'h0});
        // Reset at T+12 of a frame
        c0 = cyc;
        raise(16'sd5000, 16'sd3000);
        repeat (10) @(negedge clk);
        do_reset();
        repeat (20) @(negedge clk);
        frame(16'sd1024, 16'sd0);
        check("post_reset_0", bus.audioOut, {16'hff4f, 16'h0});
        frame(16'sd0, 16'sd0);
        check("post_reset_1", bus.audioOut, {16'd440, 16'h0});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
